// File: rtl/uart_boot_loader_if.sv
// UART byte stream and both BRAM ports (CPU side and memory side) seen by the boot loader.
interface uart_boot_loader_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic [7:0]            tx_data;
   logic                  tx_start;
   logic                  tx_busy;

   logic                  cpu_bram_ena;
   logic                  cpu_bram_wea;
   logic [ADDR_WIDTH-1:0] cpu_bram_addra;
   logic [DATA_WIDTH-1:0] cpu_bram_dina;
   logic [DATA_WIDTH-1:0] cpu_bram_douta;

   logic                  bram_ena;
   logic                  bram_wea;
   logic [ADDR_WIDTH-1:0] bram_addra;
   logic [DATA_WIDTH-1:0] bram_dina;
   logic [DATA_WIDTH-1:0] bram_douta;

   modport master (
      input  rx_data, rx_valid, tx_busy,
      input  cpu_bram_ena, cpu_bram_wea, cpu_bram_addra, cpu_bram_dina,
      input  bram_douta,
      output tx_data, tx_start, cpu_bram_douta,
      output bram_ena, bram_wea, bram_addra, bram_dina
   );

   modport slave (
      output rx_data, rx_valid, tx_busy,
      output cpu_bram_ena, cpu_bram_wea, cpu_bram_addra, cpu_bram_dina,
      output bram_douta,
      input  tx_data, tx_start, cpu_bram_douta,
      input  bram_ena, bram_wea, bram_addra, bram_dina
   );
endinterface

// File: rtl/uart_boot_loader.sv
// Host-driven boot loader: parses L/R/G byte commands from the UART, owns the BRAM while
// the CPU is held in reset, and answers through the UART transmitter.
module uart_boot_loader #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 100_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_boot_loader_if.master bus,
   output logic               cpu_rst_n,
   output logic               busy
);
   localparam int unsigned TMO_WIDTH = $clog2(TIMEOUT + 1);
   localparam int unsigned CNT_WIDTH = 16;
   localparam int unsigned HDR_WIDTH = 24;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_READ = 8'h52;
   localparam logic [7:0] CMD_GO   = 8'h47;
   localparam logic [7:0] BYTE_ACK = 8'h06;
   localparam logic [7:0] BYTE_NAK = 8'h15;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_HDR    = 4'd1;
   localparam logic [3:0] ST_LDATA  = 4'd2;
   localparam logic [3:0] ST_LWRITE = 4'd3;
   localparam logic [3:0] ST_RREAD  = 4'd4;
   localparam logic [3:0] ST_RWAIT  = 4'd5;
   localparam logic [3:0] ST_RSEND  = 4'd6;
   localparam logic [3:0] ST_ACK    = 4'd7;
   localparam logic [3:0] ST_NAK    = 4'd8;

   logic [3:0]            state_q,     state_d;
   logic                  is_read_q,   is_read_d;
   logic                  is_go_q,     is_go_d;
   logic                  sent_q,      sent_d;
   logic [1:0]            idx_q,       idx_d;
   logic [HDR_WIDTH-1:0]  hdr_q,       hdr_d;
   logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
   logic [CNT_WIDTH-1:0]  cnt_q,       cnt_d;
   logic [DATA_WIDTH-1:0] word_q,      word_d;
   logic [TMO_WIDTH-1:0]  tmo_q,       tmo_d;
   logic                  tx_start_q,  tx_start_d;
   logic                  tx_gap_q,    tx_gap_d;
   logic [7:0]            tx_data_q,   tx_data_d;
   logic                  cpu_rst_n_q, cpu_rst_n_d;
   logic                  busy_q,      busy_d;
   logic                  ld_ena_q,    ld_ena_d;
   logic                  ld_wea_q,    ld_wea_d;
   logic [ADDR_WIDTH-1:0] ld_addr_q,   ld_addr_d;
   logic [DATA_WIDTH-1:0] ld_din_q,    ld_din_d;

   logic                  rx_take;
   logic                  can_tx;
   logic                  tmo_hit;
   logic [31:0]           hdr_next;
   logic [DATA_WIDTH-1:0] word_next;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         is_read_q   <= 1'b0;
         is_go_q     <= 1'b0;
         sent_q      <= 1'b0;
         idx_q       <= '0;
         hdr_q       <= '0;
         addr_q      <= '0;
         cnt_q       <= '0;
         word_q      <= '0;
         tmo_q       <= '0;
         tx_start_q  <= 1'b0;
         tx_gap_q    <= 1'b0;
         tx_data_q   <= '0;
         cpu_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         ld_ena_q    <= 1'b0;
         ld_wea_q    <= 1'b0;
         ld_addr_q   <= '0;
         ld_din_q    <= '0;
      end else begin
         state_q     <= state_d;
         is_read_q   <= is_read_d;
         is_go_q     <= is_go_d;
         sent_q      <= sent_d;
         idx_q       <= idx_d;
         hdr_q       <= hdr_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         tmo_q       <= tmo_d;
         tx_start_q  <= tx_start_d;
         tx_gap_q    <= tx_gap_d;
         tx_data_q   <= tx_data_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         busy_q      <= busy_d;
         ld_ena_q    <= ld_ena_d;
         ld_wea_q    <= ld_wea_d;
         ld_addr_q   <= ld_addr_d;
         ld_din_q    <= ld_din_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      is_read_d   = is_read_q;
      is_go_d     = is_go_q;
      sent_d      = sent_q;
      idx_d       = idx_q;
      hdr_d       = hdr_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      tmo_d       = tmo_q + 1'b1;
      tx_start_d  = 1'b0;
      tx_gap_d    = tx_start_q;
      tx_data_d   = tx_data_q;
      cpu_rst_n_d = cpu_rst_n_q;
      ld_ena_d    = 1'b0;
      ld_wea_d    = 1'b0;
      ld_addr_d   = ld_addr_q;
      ld_din_d    = ld_din_q;
      rx_take     = 1'b0;

      hdr_next  = {hdr_q, bus.rx_data};
      word_next = {word_q[DATA_WIDTH-9:0], bus.rx_data};
      // Never restart the transmitter on the pulse cycle or the one right after it
      can_tx    = !bus.tx_busy && !tx_start_q && !tx_gap_q;
      tmo_hit   = (tmo_q == TMO_WIDTH'(TIMEOUT - 1));

      case (state_q)
         ST_IDLE: begin
            if (bus.rx_valid) begin
               rx_take = 1'b1;
               idx_d   = '0;
               sent_d  = 1'b0;
               is_go_d = (bus.rx_data == CMD_GO);
               if (bus.rx_data == CMD_LOAD || bus.rx_data == CMD_READ) begin
                  is_read_d   = (bus.rx_data == CMD_READ);
                  cpu_rst_n_d = 1'b0;
                  state_d     = ST_HDR;
               end else if (bus.rx_data == CMD_GO) begin
                  state_d = ST_ACK;
                  // Release the CPU together with the ACK pulse when the UART is free
                  if (can_tx) begin
                     tx_start_d  = 1'b1;
                     tx_data_d   = BYTE_ACK;
                     cpu_rst_n_d = 1'b1;
                     sent_d      = 1'b1;
                  end
               end else begin
                  state_d = ST_NAK;
               end
            end
         end

         ST_HDR: begin
            if (bus.rx_valid) begin
               rx_take = 1'b1;
               hdr_d   = hdr_next[HDR_WIDTH-1:0];
               idx_d   = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  addr_d = ADDR_WIDTH'(hdr_next[31:16]);
                  cnt_d  = hdr_next[15:0];
                  sent_d = 1'b0;
                  if (hdr_next[15:0] == '0) begin
                     state_d = ST_ACK;
                  end else if (is_read_q) begin
                     ld_ena_d  = 1'b1;
                     ld_addr_d = ADDR_WIDTH'(hdr_next[31:16]);
                     state_d   = ST_RREAD;
                  end else begin
                     state_d = ST_LDATA;
                  end
               end
            end else if (tmo_hit) begin
               sent_d  = 1'b0;
               state_d = ST_NAK;
            end
         end

         ST_LDATA: begin
            if (bus.rx_valid) begin
               rx_take = 1'b1;
               word_d  = word_next;
               idx_d   = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  ld_ena_d  = 1'b1;
                  ld_wea_d  = 1'b1;
                  ld_addr_d = addr_q;
                  ld_din_d  = word_next;
                  state_d   = ST_LWRITE;
               end
            end else if (tmo_hit) begin
               sent_d  = 1'b0;
               state_d = ST_NAK;
            end
         end

         ST_LWRITE: begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
            // A byte landing on the write cycle starts the next word
            if (bus.rx_valid) begin
               rx_take = 1'b1;
               word_d  = word_next;
               idx_d   = idx_q + 2'd1;
            end
            if (cnt_q == CNT_WIDTH'(1)) begin
               sent_d  = 1'b0;
               state_d = ST_ACK;
            end else begin
               state_d = ST_LDATA;
            end
         end

         ST_RREAD: state_d = ST_RWAIT;

         ST_RWAIT: begin
            word_d  = bus.bram_douta;
            idx_d   = '0;
            state_d = ST_RSEND;
         end

         ST_RSEND: begin
            if (can_tx) begin
               tx_start_d = 1'b1;
               tx_data_d  = word_q[DATA_WIDTH-1 -: 8];
               word_d     = {word_q[DATA_WIDTH-9:0], 8'h00};
               idx_d      = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  if (cnt_q == CNT_WIDTH'(1)) begin
                     sent_d  = 1'b0;
                     state_d = ST_ACK;
                  end else begin
                     addr_d    = addr_q + 1'b1;
                     cnt_d     = cnt_q - 1'b1;
                     ld_ena_d  = 1'b1;
                     ld_addr_d = addr_q + 1'b1;
                     state_d   = ST_RREAD;
                  end
               end
            end
         end

         ST_ACK, ST_NAK: begin
            if (sent_q) begin
               state_d = ST_IDLE;
            end else if (can_tx) begin
               tx_start_d = 1'b1;
               tx_data_d  = (state_q == ST_ACK) ? BYTE_ACK : BYTE_NAK;
               if (state_q == ST_ACK && is_go_q) begin
                  cpu_rst_n_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (rx_take || state_d != state_q) begin
         tmo_d = '0;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // BRAM port ownership follows the registered CPU reset
   assign bus.bram_ena       = cpu_rst_n_q ? bus.cpu_bram_ena   : ld_ena_q;
   assign bus.bram_wea       = cpu_rst_n_q ? bus.cpu_bram_wea   : ld_wea_q;
   assign bus.bram_addra     = cpu_rst_n_q ? bus.cpu_bram_addra : ld_addr_q;
   assign bus.bram_dina      = cpu_rst_n_q ? bus.cpu_bram_dina  : ld_din_q;
   assign bus.cpu_bram_douta = bus.bram_douta;

   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign cpu_rst_n    = cpu_rst_n_q;
   assign busy         = busy_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with a behavioural BRAM and UART transmitter.
module tb_uart_boot_loader;
   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 40;

   logic clk;
   logic rst_n;
   logic cpu_rst_n;
   logic busy;

   uart_boot_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   uart_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .cpu_rst_n (cpu_rst_n),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model: synchronous write, read data one cycle after ena
   logic [DW-1:0] mem [0:65535];
   logic [DW-1:0] douta;
   int            wr_cnt;
   int            ena_cnt;
   initial begin
      douta   = '0;
      wr_cnt  = 0;
      ena_cnt = 0;
   end
   always @(posedge clk) begin
      if (bus.bram_ena) begin
         ena_cnt <= ena_cnt + 1;
         douta   <= mem[bus.bram_addra];
         if (bus.bram_wea) begin
            mem[bus.bram_addra] <= bus.bram_dina;
            wr_cnt              <= wr_cnt + 1;
         end
      end
   end
   assign bus.bram_douta = douta;

   // UART transmitter model: busy for 6 cycles after each start
   logic [7:0] tx_log [0:255];
   int         tx_wr;
   int         tx_rd;
   int         bcnt;
   int         viol;
   initial begin
      tx_wr = 0;
      bcnt  = 0;
      viol  = 0;
   end
   always @(posedge clk) begin
      if (bus.tx_start) begin
         if (bus.tx_busy) viol <= viol + 1;
         tx_log[tx_wr % 256] <= bus.tx_data;
         tx_wr               <= tx_wr + 1;
         bcnt                <= 6;
      end else if (bcnt != 0) begin
         bcnt <= bcnt - 1;
      end
   end
   assign bus.tx_busy = (bcnt != 0);

   int n_checks;
   int n_errors;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   logic [7:0] seq [$];

   task automatic send_seq(input int gap);
      foreach (seq[i]) send_byte(seq[i], gap);
   endtask

   // 0x1FF marks "no byte arrived within the budget"
   task automatic expect_tx(input string tag, input logic [7:0] exp, output int waited);
      logic [8:0] got;
      waited = 0;
      while (tx_wr == tx_rd && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      got = (tx_wr == tx_rd) ? 9'h1FF : {1'b0, tx_log[tx_rd % 256]};
      check_eq(tag, 64'(got), 64'({1'b0, exp}));
      if (tx_wr != tx_rd) tx_rd++;
   endtask

   int w;
   int wr0;
   int ena0;

   initial begin
      n_checks = 0;
      n_errors = 0;
      tx_rd    = 0;
      rst_n    = 1'b0;
      bus.rx_data        = '0;
      bus.rx_valid       = 1'b0;
      bus.cpu_bram_ena   = 1'b0;
      bus.cpu_bram_wea   = 1'b0;
      bus.cpu_bram_addra = '0;
      bus.cpu_bram_dina  = '0;
      repeat (3) @(negedge clk);

      check_eq("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      check_eq("rst_busy",      64'(busy), 64'd0);
      check_eq("rst_tx",        64'({bus.tx_start, bus.tx_data}), 64'd0);
      check_eq("rst_bram",      64'({bus.bram_ena, bus.bram_wea, bus.bram_addra, bus.bram_dina}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Go: CPU released together with the ACK pulse, one cycle after the byte
      send_byte(8'h47, 0);
      check_eq("go_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
      check_eq("go_tx_pulse",  64'({bus.tx_start, bus.tx_data}), 64'h106);
      expect_tx("go_ack", 8'h06, w);

      bus.cpu_bram_ena   = 1'b1;
      bus.cpu_bram_wea   = 1'b1;
      bus.cpu_bram_addra = 16'h1234;
      bus.cpu_bram_dina  = 32'hCAFE_F00D;
      #1;
      check_eq("passthru", 64'({bus.bram_ena, bus.bram_wea, bus.bram_addra, bus.bram_dina}),
               {14'd0, 1'b1, 1'b1, 16'h1234, 32'hCAFE_F00D});
      @(negedge clk);
      bus.cpu_bram_ena = 1'b0;
      bus.cpu_bram_wea = 1'b0;
      @(negedge clk);

      // Load two words at 0x0010
      wr0  = wr_cnt;
      ena0 = ena_cnt;
      seq = {8'h4C, 8'h00, 8'h10, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
      send_seq(2);
      expect_tx("load_ack", 8'h06, w);
      check_eq("load_mem10", 64'(mem[16'h0010]), 64'hDEAD_BEEF);
      check_eq("load_mem11", 64'(mem[16'h0011]), 64'h0102_0304);
      check_eq("load_wr_cycles", 64'(wr_cnt - wr0), 64'd2);
      check_eq("load_ena_cycles", 64'(ena_cnt - ena0), 64'd2);
      check_eq("load_cpu_held", 64'(cpu_rst_n), 64'd0);

      // Read them back
      ena0 = ena_cnt;
      seq = {8'h52, 8'h00, 8'h10, 8'h00, 8'h02};
      send_seq(1);
      expect_tx("rd_b0", 8'hDE, w);
      expect_tx("rd_b1", 8'hAD, w);
      expect_tx("rd_b2", 8'hBE, w);
      expect_tx("rd_b3", 8'hEF, w);
      expect_tx("rd_b4", 8'h01, w);
      expect_tx("rd_b5", 8'h02, w);
      expect_tx("rd_b6", 8'h03, w);
      expect_tx("rd_b7", 8'h04, w);
      expect_tx("rd_ack", 8'h06, w);
      check_eq("rd_ena_cycles", 64'(ena_cnt - ena0), 64'd2);
      check_eq("rd_no_start_while_busy", 64'(viol), 64'd0);

      // Wrapping load, bytes back-to-back so one lands on the write cycle
      wr0 = wr_cnt;
      seq = {8'h4C, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_seq(0);
      expect_tx("wrap_ack", 8'h06, w);
      check_eq("wrap_memffff", 64'(mem[16'hFFFF]), 64'h1122_3344);
      check_eq("wrap_mem0000", 64'(mem[16'h0000]), 64'h5566_7788);
      check_eq("wrap_wr_cycles", 64'(wr_cnt - wr0), 64'd2);

      // Zero-count load: ACK only
      ena0 = ena_cnt;
      seq = {8'h4C, 8'h00, 8'h00, 8'h00, 8'h00};
      send_seq(1);
      expect_tx("zero_ack", 8'h06, w);
      check_eq("zero_no_ena", 64'(ena_cnt - ena0), 64'd0);

      // Unknown command byte
      send_byte(8'h41, 0);
      expect_tx("unk_nak", 8'h15, w);
      repeat (2) @(negedge clk);
      check_eq("unk_idle", 64'(busy), 64'd0);

      // Partial word then silence: inter-byte timeout
      wr0 = wr_cnt;
      seq = {8'h4C, 8'h00, 8'h10, 8'h00, 8'h01, 8'hAA, 8'hBB};
      send_seq(1);
      expect_tx("tmo_nak", 8'h15, w);
      check_eq("tmo_not_early", 64'(w >= int'(TMO)), 64'd1);
      check_eq("tmo_not_late",  64'(w <= int'(TMO) + 10), 64'd1);
      check_eq("tmo_no_write",  64'(wr_cnt - wr0), 64'd0);
      check_eq("tmo_mem_kept",  64'(mem[16'h0010]), 64'hDEAD_BEEF);
      repeat (2) @(negedge clk);
      check_eq("tmo_idle", 64'(busy), 64'd0);

      // CPU running with BRAM traffic, then a read takes the BRAM back
      send_byte(8'h47, 0);
      expect_tx("go2_ack", 8'h06, w);
      bus.cpu_bram_ena   = 1'b1;
      bus.cpu_bram_wea   = 1'b0;
      bus.cpu_bram_addra = 16'h0005;
      @(negedge clk);
      check_eq("cpu_run_passthru", 64'({cpu_rst_n, bus.bram_ena, bus.bram_addra}), {46'd0, 2'b11, 16'h0005});
      send_byte(8'h52, 0);
      check_eq("rd_halt_cpu", 64'({cpu_rst_n, bus.bram_ena}), 64'd0);
      seq = {8'h00, 8'h00, 8'h00, 8'h01};
      send_seq(1);
      expect_tx("halt_rd_b0", 8'h55, w);

      // Reset in the middle of the response
      rst_n = 1'b0;
      #1;
      check_eq("midrst_tx_start", 64'(bus.tx_start), 64'd0);
      check_eq("midrst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      check_eq("midrst_busy", 64'(busy), 64'd0);
      check_eq("midrst_loader_owns", 64'(bus.bram_ena), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("midrst_silent", 64'(tx_wr - tx_rd), 64'd0);
      tx_rd = tx_wr;
      bus.cpu_bram_ena = 1'b0;
      send_byte(8'h41, 0);
      expect_tx("post_rst_nak", 8'h15, w);
      check_eq("final_no_start_while_busy", 64'(viol), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
